// File: rtl/evt_arb_pkg.sv
// Shared types and helpers for the event stream arbiter.
package evt_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of a source index; never collapses to zero bits.
  function automatic int SRC_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/evt_arb_rr_sel.sv
// Cyclic first-set search over the request vector, starting at ptr.
module evt_arb_rr_sel
  import evt_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]            req,
  input  logic [SRC_ID_W(N_SRC)-1:0]  ptr,
  output logic [SRC_ID_W(N_SRC)-1:0]  idx,
  output logic                        found
);

  localparam int IW = SRC_ID_W(N_SRC);

  int j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_SRC; i++) begin
      j = int'(ptr) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/evt_stream_arbiter.sv
// Burst round-robin merge of N_SRC event streams into one registered output.
// Optional per-source grant counters are enabled with EVT_ARB_STATS_EN.
module evt_stream_arbiter
  import evt_arb_pkg::*;
#(
  parameter type T       = logic,
  parameter int  N_SRC   = 4,
  parameter int  BURST_W = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [BURST_W-1:0]          burst_len_i,
  input  T                            in_evt_i [N_SRC],
  input  logic [N_SRC-1:0]            in_valid_i,
  output logic [N_SRC-1:0]            in_ready_o,
  output T                            out_evt_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [SRC_ID_W(N_SRC)-1:0]  out_src_id_o
`ifdef EVT_ARB_STATS_EN
  ,
  output logic [31:0]                 grant_cnt_o [N_SRC]
`endif
);

  localparam int IW = SRC_ID_W(N_SRC);

  arb_state_e         state;
  logic [IW-1:0]      grant, rr_ptr, sel_idx, grant_nxt;
  logic               sel_found;
  logic [BURST_W-1:0] burst_cnt, burst_max;
  logic               out_free, active, xfer, burst_last;

  evt_arb_rr_sel #(.N_SRC(N_SRC)) u_sel (
    .req   (in_valid_i),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Ready is a function of state and the output stage only, never of in_valid_i.
  assign out_free   = !out_valid_o || out_ready_i;
  assign active     = enable_i && (state == ST_BURST) && out_free;
  assign xfer       = active && in_valid_i[grant];
  assign burst_last = (burst_cnt + BURST_W'(1)) == burst_max;
  assign grant_nxt  = (grant == IW'(N_SRC - 1)) ? '0 : grant + IW'(1);

  always_comb begin
    in_ready_o = '0;
    if (active) in_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      burst_max <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i && sel_found) begin
            state     <= ST_BURST;
            grant     <= sel_idx;
            burst_cnt <= '0;
            burst_max <= (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
          end
        end
        ST_BURST: begin
          // Disable aborts the burst without advancing the pointer.
          if (!enable_i) begin
            state <= ST_IDLE;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
            if (burst_last) begin
              state  <= ST_IDLE;
              rr_ptr <= grant_nxt;
            end
          end else if (!in_valid_i[grant]) begin
            state  <= ST_IDLE;
            rr_ptr <= grant_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o  <= 1'b0;
      out_src_id_o <= '0;
      out_evt_o    <= '0;
    end else if (out_free) begin
      out_valid_o <= xfer;
      if (xfer) begin
        out_evt_o    <= in_evt_i[grant];
        out_src_id_o <= grant;
      end
    end
  end

`ifdef EVT_ARB_STATS_EN
  for (genvar g = 0; g < N_SRC; g++) begin : g_stats
    always_ff @(posedge clk_i) begin
      if (rst_i)
        grant_cnt_o[g] <= '0;
      else if (xfer && (grant == IW'(g)) && (grant_cnt_o[g] != 32'hFFFF_FFFF))
        grant_cnt_o[g] <= grant_cnt_o[g] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_evt_stream_arbiter.sv
// Randomized bench for evt_stream_arbiter against a transaction-level reference.
module tb_evt_stream_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int IW = 2;
  typedef logic [7:0] evt_t;

  logic           clk = 1'b0;
  logic           rst, enable, out_ready, out_valid;
  logic [BW-1:0]  burst_len;
  evt_t           in_evt [N];
  logic [N-1:0]   in_valid, in_ready;
  evt_t           out_evt;
  logic [IW-1:0]  out_src;
`ifdef EVT_ARB_STATS_EN
  logic [31:0]    gcnt [N];
`endif

  always #5 clk = ~clk;

  evt_stream_arbiter #(.T(evt_t), .N_SRC(N), .BURST_W(BW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .burst_len_i  (burst_len),
    .in_evt_i     (in_evt),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_evt_o    (out_evt),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_src_id_o (out_src)
`ifdef EVT_ARB_STATS_EN
    ,
    .grant_cnt_o  (gcnt)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: busy flag, granted source, grants remaining, next search start.
  bit     m_busy;
  int     m_g, m_left, m_ptr;
  bit     m_ov;
  evt_t   m_evt;
  int     m_src;
  longint m_cnt [N];
  evt_t   sb [N][$];

  int p_valid, p_ready, p_en;
  logic [N-1:0] src_mask;
  int seq [N];
  bit rec_on;
  int osrc [$];

  task automatic cycle(input bit r);
    logic [N-1:0] exp_ready;
    bit xf;
    int xg, s;
    rst       = r;
    out_ready = ($urandom_range(99) < p_ready);
    enable    = ($urandom_range(99) < p_en);
    for (int k = 0; k < N; k++)
      if (!in_valid[k] && src_mask[k] && ($urandom_range(99) < p_valid)) begin
        in_valid[k] = 1'b1;
        in_evt[k]   = {2'(k), 6'(seq[k])};
        seq[k]++;
      end
    #1;
    exp_ready = '0;
    if (m_busy && enable && (!m_ov || out_ready)) exp_ready[m_g] = 1'b1;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_evt", out_evt, m_evt);
      chk("out_src", out_src, m_src);
    end
`ifdef EVT_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk("grant_cnt", gcnt[k], m_cnt[k]);
`endif
    xf = exp_ready[m_g] && in_valid[m_g];
    xg = m_g;
    if (r) begin
      m_busy = 0; m_g = 0; m_left = 0; m_ptr = 0;
      m_ov = 0; m_evt = '0; m_src = 0;
      for (int k = 0; k < N; k++) begin m_cnt[k] = 0; sb[k].delete(); end
      xf = 0;
    end else begin
      if (m_ov && out_ready) begin
        if (sb[m_src].size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_order", out_evt, sb[m_src].pop_front());
        if (rec_on) osrc.push_back(int'(out_src));
      end
      if (xf) begin
        sb[xg].push_back(in_evt[xg]);
        if (m_cnt[xg] < 64'hFFFF_FFFF) m_cnt[xg]++;
      end
      if (!m_ov || out_ready) begin
        m_ov = xf;
        if (xf) begin m_evt = in_evt[xg]; m_src = xg; end
      end
      if (!m_busy) begin
        if (enable && (in_valid != '0)) begin
          for (int k = N - 1; k >= 0; k--) begin
            s = (m_ptr + k) % N;
            if (in_valid[s]) m_g = s;
          end
          m_busy = 1;
          m_left = (burst_len == 0) ? 1 : int'(burst_len);
        end
      end else if (!enable) begin
        m_busy = 0;
      end else if (xf) begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_ptr = (m_g + 1) % N; end
      end else if (!in_valid[m_g]) begin
        m_busy = 0; m_ptr = (m_g + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (xf) in_valid[xg] = 1'b0;
  endtask

  task automatic restart();
    in_valid = '0;
    cycle(1'b1);
    cycle(1'b1);
  endtask

  int exp27 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  evt_t hold;

  initial begin
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; burst_len = 8'd2;
    in_valid = '0; rec_on = 0;
    for (int k = 0; k < N; k++) begin in_evt[k] = '0; seq[k] = 0; end
    p_valid = 100; p_ready = 100; p_en = 100; src_mask = '0;
    @(negedge clk);
    restart();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'b0);
    chk("rst_out_src", out_src, 2'd0);

    // All valid, burst of two, always ready.
    src_mask = '1; burst_len = 8'd2; rec_on = 1;
    repeat (40) cycle(1'b0);
    rec_on = 0;
    for (int k = 0; k < 9; k++)
      if (k < osrc.size()) chk("rr_order", osrc[k], exp27[k]);
      else chk("rr_order_short", osrc.size(), 9);

    // Lone source 2 with zero burst length, then release the others.
    src_mask = 4'b0100; burst_len = 8'd0;
    restart();
    repeat (20) cycle(1'b0);
    src_mask = '1;
    repeat (20) cycle(1'b0);

    // Five-cycle output stall mid-burst.
    burst_len = 8'd4;
    repeat (6) cycle(1'b0);
    p_ready = 0;
    cycle(1'b0);
    hold = out_evt;
    repeat (4) begin
      cycle(1'b0);
      chk("stall_hold", out_evt, hold);
    end
    p_ready = 100;
    repeat (20) cycle(1'b0);

    // Sparse sources so bursts end on dropped valid.
    p_valid = 30;
    repeat (200) cycle(1'b0);

    // Enable toggling with backpressure.
    p_valid = 70; p_en = 80; p_ready = 70;
    repeat (300) cycle(1'b0);

    // Reset while the output stage holds an event.
    p_en = 100; p_valid = 100; p_ready = 100;
    repeat (5) cycle(1'b0);
    p_ready = 0;
    repeat (3) cycle(1'b0);
    chk("full_before_rst", out_valid, 1'b1);
    cycle(1'b1);
    chk("rst_flush", out_valid, 1'b0);
    p_ready = 100;

    // Fully random.
    for (int b = 0; b < 40; b++) begin
      burst_len = 8'($urandom_range(5));
      p_valid = $urandom_range(20, 100);
      p_ready = $urandom_range(30, 100);
      p_en    = $urandom_range(70, 100);
      repeat (50) cycle(1'b0);
    end
    for (int k = 0; k < N; k++) chk("sb_residue", (sb[k].size() > 1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
